// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for NeanderRV64I load/store requests. Accepts one
//   request at a time, performs a little-endian access on an internal array
//   of 64-bit words after a configurable latency, and returns extended load
//   data or a store completion over a valid/ready response handshake.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE only)
//   load       in   request is a load
//   store      in   request is a store
//   funct3     in   size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//   addr       in   byte address; word index is addr[63:3]
//   wdata      in   store data, low bytes used according to size
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rdata      out  extended load result; 0 for stores and errors
//   rsp_err    out  request rejected, no memory side effect
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rdata,
    output logic        rsp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q;
    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [63:0]    rdata_q;
    logic           rsp_err_q;
    logic [CW-1:0]  cnt_q;

    logic           load_q;
    logic           store_q;
    logic [2:0]     funct3_q;
    logic [63:0]    addr_q;
    logic [63:0]    wdata_q;

    logic [63:0]    mem [DEPTH];

    logic           misalign_c;
    logic           oor_c;
    logic           err_c;
    logic [IW-1:0]  idx_c;
    logic [63:0]    rd_word_c;
    logic [63:0]    rd_shift_c;
    logic [63:0]    ld_ext_c;
    logic [7:0]     size_mask_c;
    logic [7:0]     be_c;
    logic [63:0]    wd_shift_c;
    logic [63:0]    wr_word_d;
    logic           access_c;
    logic           we_c;

    // Request checks and lane handling, all from the latched request.
    always_comb begin
        misalign_c = 1'b0;
        case (funct3_q[1:0])
            2'b01:   misalign_c = addr_q[0];
            2'b10:   misalign_c = (addr_q[1:0] != 2'b00);
            2'b11:   misalign_c = (addr_q[2:0] != 3'b000);
            default: misalign_c = 1'b0;
        endcase

        oor_c = (addr_q[63:3] >= 61'(DEPTH));
        err_c = (load_q == store_q) || (funct3_q == 3'b111) ||
                (store_q && funct3_q[2]) || misalign_c || oor_c;

        idx_c      = addr_q[IW+2:3];
        rd_word_c  = mem[idx_c];
        // Alignment is enforced, so a byte-granular shift also selects the
        // half and word lanes.
        rd_shift_c = rd_word_c >> {addr_q[2:0], 3'b000};

        ld_ext_c = '0;
        case (funct3_q)
            3'b000:  ld_ext_c = {{56{rd_shift_c[7]}},  rd_shift_c[7:0]};
            3'b001:  ld_ext_c = {{48{rd_shift_c[15]}}, rd_shift_c[15:0]};
            3'b010:  ld_ext_c = {{32{rd_shift_c[31]}}, rd_shift_c[31:0]};
            3'b011:  ld_ext_c = rd_shift_c;
            3'b100:  ld_ext_c = {56'd0, rd_shift_c[7:0]};
            3'b101:  ld_ext_c = {48'd0, rd_shift_c[15:0]};
            3'b110:  ld_ext_c = {32'd0, rd_shift_c[31:0]};
            default: ld_ext_c = '0;
        endcase

        size_mask_c = 8'h00;
        case (funct3_q[1:0])
            2'b00:   size_mask_c = 8'h01;
            2'b01:   size_mask_c = 8'h03;
            2'b10:   size_mask_c = 8'h0F;
            default: size_mask_c = 8'hFF;
        endcase
        be_c       = size_mask_c << addr_q[2:0];
        wd_shift_c = wdata_q << {addr_q[2:0], 3'b000};

        wr_word_d = rd_word_c;
        for (int unsigned i = 0; i < 8; i++) begin
            if (be_c[i]) begin
                wr_word_d[8*i +: 8] = wd_shift_c[8*i +: 8];
            end
        end

        access_c = (state_q == WAIT) && (cnt_q == CW'(1));
        we_c     = access_c && store_q && !err_c && !reset;
    end

    // Memory is not reset; a reset forces IDLE, which removes the write.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[idx_c] <= wr_word_d;
        end
    end

    // The accepting edge only latches the request; WAIT then always spans
    // LATENCY cycles, so rsp_valid rises exactly LATENCY edges after accept
    // and the memory access lands on the edge that enters RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        load_q      <= load;
                        store_q     <= store;
                        funct3_q    <= funct3;
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        cnt_q       <= CW'(LATENCY);
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_c;
                        rdata_q     <= (err_c || store_q) ? '0 : ld_ext_c;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign rsp_err   = rsp_err_q;

    a_valid_ready_excl: assert property (@(posedge clk) disable iff (reset)
        !(rsp_valid && req_ready));

    a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> ($stable(rdata) && $stable(rsp_err)));

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    byte unsigned mref [DEPTH*8];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .load      (load),
        .store     (store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-array reference: size = 1 << funct3[1:0], little-endian.
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [63:0] a, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic er);
        int unsigned sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v  = '0;
        rd = '0;
        er = (ld == st) || (f3 == 3'b111) || (st && f3[2]) ||
             ((a % sz) != 0) || ((a >> 3) >= DEPTH);
        if (er) return;
        if (st) begin
            for (int i = 0; i < int'(sz); i++) mref[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = mref[a + i];
            if (!f3[2] && sz < 8 && v[8*sz - 1]) v = v | ({64{1'b1}} << (8*sz));
            rd = v;
        end
    endfunction

    task automatic xact(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input int bp,
                        input bit pulse, output logic [63:0] got);
        logic [63:0] erd;
        logic        eer;
        logic [63:0] rd0;
        logic        er0;
        int          cyc;
        model(ld, st, f3, a, wd, erd, eer);
        got = '0;
        @(negedge clk);
        check({tag, ".req_ready"}, req_ready, 1);
        rsp_ready = (bp == 0);
        req_valid = 1'b1;
        load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        load = 1'($urandom); store = 1'($urandom); funct3 = 3'($urandom);
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), LAT);
        if (!rsp_valid) begin
            rsp_ready = 1'b0;
            return;
        end
        got = rdata;
        check({tag, ".rdata"}, rdata, erd);
        check({tag, ".err"}, rsp_err, eer);
        check({tag, ".busy"}, req_ready, 0);
        rd0 = rdata;
        er0 = rsp_err;
        for (int i = 0; i < bp; i++) begin
            if (pulse && i == 0) req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            check({tag, ".hold_valid"}, rsp_valid, 1);
            check({tag, ".hold_rdata"}, rdata, rd0);
            check({tag, ".hold_err"}, rsp_err, er0);
            check({tag, ".hold_busy"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, rsp_valid, 0);
        check({tag, ".done_ready"}, req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        logic [63:0] old20;
        logic [63:0] dummy;
        logic        er;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.req_ready", req_ready, 1);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.rdata", rdata, 0);
        check("rst.rsp_err", rsp_err, 0);
        reset = 1'b0;

        // Give every word a known value.
        for (int w = 0; w < DEPTH; w++)
            xact("init", 0, 1, 3'b011, 64'(w*8), {$urandom, $urandom}, 0, 0, got);

        xact("sd10", 0, 1, 3'b011, 64'h10, 64'h8877665544332211, 1, 0, got);
        xact("ld10", 1, 0, 3'b011, 64'h10, 64'h0, 0, 0, got);
        check("ld10.value", got, 64'h8877665544332211);
        xact("lb17", 1, 0, 3'b000, 64'h17, 64'h0, 0, 0, got);
        check("lb17.value", got, 64'hFFFFFFFFFFFFFF88);
        xact("lbu17", 1, 0, 3'b100, 64'h17, 64'h0, 2, 0, got);
        check("lbu17.value", got, 64'h88);
        xact("lh16", 1, 0, 3'b001, 64'h16, 64'h0, 0, 0, got);
        check("lh16.value", got, 64'hFFFFFFFFFFFF8877);
        xact("lwu14", 1, 0, 3'b110, 64'h14, 64'h0, 0, 0, got);
        check("lwu14.value", got, 64'h88776655);

        xact("sb11", 0, 1, 3'b000, 64'h11, 64'hAB, 0, 0, got);
        xact("ld10b", 1, 0, 3'b011, 64'h10, 64'h0, 0, 0, got);
        check("ld10b.value", got, 64'h887766554433AB11);

        xact("lw12", 1, 0, 3'b010, 64'h12, 64'h0, 0, 0, got);
        xact("sd_oor", 0, 1, 3'b011, 64'(8*DEPTH), {$urandom, $urandom}, 0, 0, got);
        xact("ld0", 1, 0, 3'b011, 64'h0, 64'h0, 0, 0, got);
        xact("ldst", 1, 1, 3'b011, 64'h8, 64'h1234, 0, 0, got);
        xact("none", 0, 0, 3'b011, 64'h8, 64'h1234, 0, 0, got);
        xact("sbu", 0, 1, 3'b100, 64'h8, 64'h1234, 0, 0, got);
        xact("f7", 1, 0, 3'b111, 64'h8, 64'h0, 0, 0, got);

        xact("bp", 1, 0, 3'b011, 64'h10, 64'h0, 4, 1, got);

        // Abort an SD in WAIT; the word must keep its previous contents.
        model(1, 0, 3'b011, 64'h20, 64'h0, old20, er);
        @(negedge clk);
        req_valid = 1'b1; load = 1'b0; store = 1'b1; funct3 = 3'b011;
        addr = 64'h20; wdata = ~old20;
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst.rsp_valid", rsp_valid, 0);
        check("midrst.req_ready", req_ready, 1);
        check("midrst.rdata", rdata, 0);
        check("midrst.rsp_err", rsp_err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        xact("ld20", 1, 0, 3'b011, 64'h20, 64'h0, 0, 0, got);
        check("ld20.old", got, old20);

        for (int n = 0; n < 300; n++) begin
            logic        ld, st;
            logic [2:0]  f3;
            logic [63:0] a;
            int unsigned r, word, off, sz;
            r = $urandom_range(0, 15);
            if (r == 0) begin ld = 1; st = 1; end
            else if (r == 1) begin ld = 0; st = 0; end
            else begin ld = r[0]; st = !r[0]; end
            f3 = 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            word = ($urandom_range(0, 19) == 0) ? DEPTH + $urandom_range(0, 7)
                                                : $urandom_range(0, DEPTH - 1);
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
            a = 64'(word * 8 + off);
            xact("rand", ld, st, f3, a, {$urandom, $urandom},
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), dummy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
